jk_bank_arbiter: RTL
====================

// Module: jk_bank_arbiter
// PURPOSE
//  Controller and arbiter for a WIDTH-bit bank of JK flip-flops shared by two requesters (A, B).
//  Each requester issues one bank op (CLEAR / SET / TOGGLE / LOAD). The block arbitrates
//  round-robin, sequences the op through a GRANT/APPLY/DONE FSM, drives the bank's J/K
//  vectors and holds the bank state internally. Sits between the control logic and the JK storage.
// PARAMETERS
//  WIDTH   4   number of JK flip-flops in the bank (>=1)
// PORTS
//  clk     in   1      single clock, all state updates on posedge
//  rst     in   1      asynchronous, active-low reset (0 = reset)
//  req_a   in   1      requester A op request; held high until gnt_a
//  op_a    in   2      A op: 00 CLEAR, 01 SET, 10 TOGGLE, 11 LOAD
//  data_a  in   WIDTH  A operand: bit mask for CLEAR/SET/TOGGLE, value for LOAD
//  gnt_a   out  1      one-cycle grant pulse to A; op_a/data_a captured this cycle
//  req_b   in   1      as req_a, requester B
//  op_b    in   2      as op_a
//  data_b  in   WIDTH  as data_a
//  gnt_b   out  1      as gnt_a
//  j       out  WIDTH  J inputs presented to the bank (nonzero only in APPLY)
//  k       out  WIDTH  K inputs presented to the bank (nonzero only in APPLY)
//  q       out  WIDTH  bank state
//  qbar    out  WIDTH  always ~q
//  busy    out  1      high in GRANT, APPLY and DONE
//  done    out  1      one-cycle pulse; q reflects the completed op this cycle
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, q=0, qbar=all 1s, j=k=0, gnt_a=gnt_b=0, done=0, busy=0,
//   last_winner=B (so A wins the first tie). Reset mid-op aborts it: no done, q cleared.
//  Bank update every posedge: q <= (j & ~q) | (~k & q) per bit; qbar = ~q.
//   j=k=0 holds; j=0,k=1 clears; j=1,k=0 sets; j=k=1 toggles.
//  Op decode (m = captured data):
//   CLEAR  j=0,  k=m      masked bits to 0, others held
//   SET    j=m,  k=0      masked bits to 1, others held
//   TOGGLE j=m,  k=m      masked bits inverted, others held
//   LOAD   j=m,  k=~m     q takes m exactly
//  FSM:
//   IDLE:   if any req -> GRANT, else stay. j=k=0.
//   GRANT:  gnt of winner high one cycle; op/data of winner captured; last_winner updated -> APPLY.
//   APPLY:  j/k driven from captured op for exactly one cycle; q updates at end of cycle -> DONE.
//   DONE:   done=1, q valid; if any req -> GRANT (back-to-back), else -> IDLE.
//  Arbitration (evaluated entering GRANT): only one req -> that one; both -> the one not equal
//   to last_winner. No starvation: under continuous dual requests grants alternate A,B,A,B.
//  Latency: req sampled at edge n (IDLE) -> gnt in cycle n+1, j/k in n+2, done and new q in n+3.
//   Back-to-back throughput: one op per 3 cycles.
//  Requester protocol: keep req/op/data stable until gnt; op/data ignored after gnt. req still
//   high in DONE after its own gnt counts as a new request. req dropped before gnt: request
//   withdrawn, no gnt. gnt_a and gnt_b never high together.
//  Width rules: all vectors WIDTH bits, no arithmetic; op encoding fully decoded (no illegal op).
// TESTING
//  1 Reset: rst=0 mid-APPLY of SET 4'hF -> q=0, qbar=4'hF, j=k=0, no done, FSM IDLE after release.
//  2 A only: LOAD 4'hA -> gnt_a at n+1, j=4'hA,k=4'h5 at n+2, done at n+3 with q=4'hA.
//  3 Masked ops from q=4'hA: SET 4'h1 -> 4'hB; CLEAR 4'h8 -> 4'h3; TOGGLE 4'hF -> 4'hC.
//  4 Tie after reset: A and B both request continuously -> gnt order A,B,A,B, 3 cycles apart,
//    never both gnt high.
//  5 Back-to-back: B issues TOGGLE 4'h1 four times from q=0 -> q=1,0,1,0 on successive done pulses,
//    busy stays high throughout.
//  6 Withdraw: req_a pulses for one cycle while FSM busy with B -> no gnt_a, q unaffected by op_a.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: two-requester round-robin controller for a bank of JK flip-flops.
// Each granted op runs GRANT -> APPLY -> DONE. The bank state is held internally and
// updated every cycle from the registered J/K vectors.
module jk_bank_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [1:0]       op_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [1:0]       op_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_b,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_TOGGLE = 2'b10;
  localparam logic [1:0] OP_LOAD   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01,
    S_APPLY = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           r_state;
  logic             r_last_b;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic             r_gnt_a;
  logic             r_gnt_b;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qbar;
  logic             r_busy;
  logic             r_done;

  logic             w_any_req;
  logic             w_pick_b;
  logic [WIDTH-1:0] w_j_dec;
  logic [WIDTH-1:0] w_k_dec;
  logic [WIDTH-1:0] w_q_next;

  // Round-robin pick: a lone requester wins; on a tie the last winner yields.
  assign w_any_req = req_a | req_b;
  assign w_pick_b  = req_b & (~req_a | ~r_last_b);

  // JK characteristic equation for the whole bank.
  assign w_q_next = (r_j & ~r_q) | (~r_k & r_q);

  // Decode the captured op into J/K mask vectors.
  always_comb begin
    w_j_dec = '0;
    w_k_dec = '0;
    case (r_op)
      OP_CLEAR:  begin w_j_dec = '0;     w_k_dec = r_data;  end
      OP_SET:    begin w_j_dec = r_data; w_k_dec = '0;      end
      OP_TOGGLE: begin w_j_dec = r_data; w_k_dec = r_data;  end
      OP_LOAD:   begin w_j_dec = r_data; w_k_dec = ~r_data; end
      default:   begin w_j_dec = '0;     w_k_dec = '0;      end
    endcase
  end

  // Bank storage: updates every edge from the current J/K outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= '0;
      r_qbar <= '1;
    end else begin
      r_q    <= w_q_next;
      r_qbar <= ~w_q_next;
    end
  end

  // Sequencer FSM with registered grant, J/K, busy and done outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_last_b <= 1'b1;
      r_op     <= OP_CLEAR;
      r_data   <= '0;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_j      <= '0;
      r_k      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_j     <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_any_req) begin
            r_state  <= S_GRANT;
            r_busy   <= 1'b1;
            r_gnt_a  <= ~w_pick_b;
            r_gnt_b  <= w_pick_b;
            r_last_b <= w_pick_b;
            r_op     <= w_pick_b ? op_b : op_a;
            r_data   <= w_pick_b ? data_b : data_a;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_GRANT: begin
          r_state <= S_APPLY;
          r_j     <= w_j_dec;
          r_k     <= w_k_dec;
        end
        S_APPLY: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_a = r_gnt_a;
  assign gnt_b = r_gnt_b;
  assign j     = r_j;
  assign k     = r_k;
  assign q     = r_q;
  assign qbar  = r_qbar;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
